// File: rtl/alu_sequencer_if.sv
// Request channel between the instruction decode stage and the ALU sequencer.
// The decode stage holds the master side and the sequencer the slave side.
interface alu_sequencer_if;
    logic       req_valid;
    logic [3:0] req_op;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_op,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        output req_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one encoded opcode at a time and drives the one-hot
// ALU control word for LAT cycles per phase. After each phase it pulses a
// load strobe, then reports completion. MPY runs a low phase (ACC) and then
// a high phase (MR). Every output is a register updated with the state.
module alu_sequencer #(
    parameter int unsigned LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    alu_sequencer_if.slave      req_if,
    output logic [31:0]         ctrl,
    output logic                acc_load,
    output logic                mr_load,
    output logic                done,
    output logic                err,
    output logic                busy,
    output logic [15:0]         op_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        WRITE  = 3'd2,
        MPYH   = 3'd3,
        WRITEH = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [3:0]  OP_MPY   = 4'd9;
    localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);
    localparam logic [31:0] CTRL_MRH = 32'h0001_0000;

    state_t      state_r;
    logic [3:0]  op_r;
    logic [3:0]  cnt_r;
    logic [31:0] ctrl_r;
    logic        acc_load_r;
    logic        mr_load_r;
    logic        done_r;
    logic        err_r;
    logic        busy_r;
    logic        req_ready_r;
    logic [15:0] op_count_r;
    logic        hs_s;

    // Opcodes 0..9 map to an ALU function; 10..15 are rejected.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    // One-hot control word for the first (or only) phase of an opcode.
    function automatic logic [31:0] op_ctrl(input logic [3:0] op);
        logic [31:0] word;
        case (op)
            4'd0:    word = 32'h0040_0000; // ADD, bit 22
            4'd1:    word = 32'h0080_0000; // SUB, bit 23
            4'd2:    word = 32'h0100_0000; // AND, bit 24
            4'd3:    word = 32'h0200_0000; // OR,  bit 25
            4'd4:    word = 32'h0400_0000; // NOT, bit 26
            4'd5:    word = 32'h0800_0000; // SHL, bit 27
            4'd6:    word = 32'h1000_0000; // SHR, bit 28
            4'd7:    word = 32'h4000_0000; // ASL, bit 30
            4'd8:    word = 32'h8000_0000; // ASR, bit 31
            4'd9:    word = 32'h2000_0000; // MPY low phase, bit 29
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // A handshake can only happen while the sequencer advertises ready (IDLE).
    assign hs_s = req_if.req_valid & req_ready_r;

    // Sequencer FSM; outputs are registered alongside each state transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            op_r        <= 4'd0;
            cnt_r       <= 4'd0;
            ctrl_r      <= 32'h0000_0000;
            acc_load_r  <= 1'b0;
            mr_load_r   <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
            op_count_r  <= 16'd0;
        end else begin
            // Strobes are single-cycle unless a transition below re-arms them.
            acc_load_r <= 1'b0;
            mr_load_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        // Opcode is captured here; later req_op changes are ignored.
                        op_r        <= req_if.req_op;
                        busy_r      <= 1'b1;
                        req_ready_r <= 1'b0;
                        if (op_legal(req_if.req_op)) begin
                            state_r <= EXEC;
                            ctrl_r  <= op_ctrl(req_if.req_op);
                            cnt_r   <= CNT_INIT;
                        end else begin
                            state_r <= FAULT;
                            ctrl_r  <= 32'h0000_0000;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end
                    end else begin
                        ctrl_r      <= 32'h0000_0000;
                        busy_r      <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt_r == 4'd0) begin
                        state_r    <= WRITE;
                        ctrl_r     <= 32'h0000_0000;
                        acc_load_r <= 1'b1;
                        // Single-phase ops complete together with the ACC write.
                        if (op_r != OP_MPY) begin
                            done_r     <= 1'b1;
                            op_count_r <= op_count_r + 16'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                WRITE: begin
                    if (op_r == OP_MPY) begin
                        state_r <= MPYH;
                        ctrl_r  <= CTRL_MRH;
                        cnt_r   <= CNT_INIT;
                    end else begin
                        state_r     <= IDLE;
                        ctrl_r      <= 32'h0000_0000;
                        busy_r      <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                MPYH: begin
                    if (cnt_r == 4'd0) begin
                        state_r    <= WRITEH;
                        ctrl_r     <= 32'h0000_0000;
                        mr_load_r  <= 1'b1;
                        done_r     <= 1'b1;
                        op_count_r <= op_count_r + 16'd1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                WRITEH, FAULT: begin
                    state_r     <= IDLE;
                    ctrl_r      <= 32'h0000_0000;
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    // Unreachable encodings recover to a clean IDLE.
                    state_r     <= IDLE;
                    ctrl_r      <= 32'h0000_0000;
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign req_if.req_ready = req_ready_r;
    assign ctrl             = ctrl_r;
    assign acc_load         = acc_load_r;
    assign mr_load          = mr_load_r;
    assign done             = done_r;
    assign err              = err_r;
    assign busy             = busy_r;
    assign op_count         = op_count_r;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Sequences one ALU operation at a time: accepts an encoded opcode over a valid/ready handshake and drives the 32-bit one-hot control word to the ALU for a fixed number of cycles.
- Pulses the accumulator / multiplier-register load strobes, then reports completion.
- Multiply runs as two phases: low half to ACC, then high half to MR.
- Sits between the instruction decode stage and the ALU control input.

## Interface
Parameters:
- LAT, 3, cycles the control bit is held per phase before the write strobe (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state and outputs.
- req_valid  in  1  request present.
- req_op  in  4  opcode.
- req_ready  out  1  high only in IDLE; handshake completes on req_valid & req_ready at a rising edge.
- ctrl  out  32  one-hot ALU control word; all-zero when no phase is active.
- acc_load  out  1  one-cycle strobe: capture ALU ACC result.
- mr_load  out  1  one-cycle strobe: capture ALU MR result.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done for an illegal opcode.
- busy  out  1  high in every state except IDLE.
- op_count  out  16  count of legal operations completed; wraps.

## Operation
Opcode map (req_op -> ctrl bit):
- 0 ADD -> 22
- 1 SUB -> 23
- 2 AND -> 24
- 3 OR -> 25
- 4 NOT -> 26
- 5 SHL -> 27
- 6 SHR -> 28
- 7 ASL -> 30
- 8 ASR -> 31
- 9 MPY -> 29 (low phase), then 16 (high phase)
- 10..15 illegal.

States:
- IDLE → on handshake: EXEC for a legal op, FAULT for an illegal op.
- EXEC → ctrl drives the op's bit; 4-bit counter loads LAT-1 on entry and decrements each cycle; at 0 → WRITE.
- WRITE → ctrl = 0, acc_load = 1.
  - MPY → MPYH.
  - Otherwise: done = 1, op_count increments, → IDLE.
- MPYH → ctrl bit 16 held for LAT cycles (same counter scheme) → WRITEH.
- WRITEH → ctrl = 0, mr_load = 1, done = 1, op_count increments → IDLE.
- FAULT → ctrl = 0, done = 1, err = 1, op_count unchanged → IDLE.

Rules:
- Opcode is latched at the handshake; req_op changes afterwards are ignored.
- ctrl is never multi-hot. It is exactly one-hot in EXEC/MPYH and zero in all other states.
- op_count increments modulo 2^16: 0xFFFF -> 0x0000.
- req_valid while busy is ignored; no queueing.

## Timing
- All outputs are registered, decoded from the state register.
- Reset values: ctrl = 0, acc_load = 0, mr_load = 0, done = 0, err = 0, busy = 0, op_count = 0, state = IDLE, req_ready = 1 once rst deasserts.
- Handshake at edge T, legal non-MPY op:
  - ctrl valid for cycles T+1 .. T+LAT.
  - acc_load and done at cycle T+LAT+1.
  - req_ready at T+LAT+2.
- MPY:
  - bit 29 at T+1 .. T+LAT.
  - acc_load at T+LAT+1.
  - bit 16 at T+LAT+2 .. T+2·LAT+1.
  - mr_load and done at T+2·LAT+2.
- Illegal op: done and err at T+1; req_ready at T+2.
- Back-to-back: a new handshake is possible on the first IDLE cycle. Throughput is one non-MPY op per LAT+2 cycles.
- Reset mid-operation: outputs clear asynchronously. The op is abandoned with no done pulse and no op_count increment.
- LAT = 1: EXEC lasts exactly one cycle.

## Test plan
- Reset, then ADD (op 0), LAT = 3, handshake at cycle 0:
  - ctrl = 0x0040_0000 on cycles 1–3.
  - acc_load, done on cycle 4; op_count = 1.
  - req_ready on cycle 5.
- MPY (op 9):
  - ctrl = 0x2000_0000 on cycles 1–3; acc_load on cycle 4.
  - ctrl = 0x0001_0000 on cycles 5–7; mr_load and done on cycle 8.
  - acc_load and mr_load never asserted together.
- Illegal op 12: done = 1 and err = 1 on cycle 1, ctrl stays 0, op_count unchanged.
- ASR request held valid continuously while an SHL is executing:
  - req_ready = 0 during SHL.
  - SHL (bit 27) completes.
  - ASR (bit 31) is accepted on the first IDLE cycle.
- Preload op_count to 0xFFFF via 65535 legal ops, run one more: op_count = 0x0000.
- Assert rst low during EXEC of a SUB:
  - ctrl = 0 and busy = 0 immediately (asynchronous).
  - No done pulse.
  - req_ready = 1 after release.
